// File: rtl/logic_op_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_pkg
// Description : Opcode encoding and bitwise-logic helpers shared by the
//               responder RTL and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_op_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    // Single-bit kernel; wider datapaths replicate it per bit.
    function automatic logic apply_bit(input logic a, input logic b, input op_e op);
        logic y;
        y = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    function automatic logic [DEFAULT_WIDTH-1:0] apply_op(
        input logic [DEFAULT_WIDTH-1:0] a,
        input logic [DEFAULT_WIDTH-1:0] b,
        input op_e                      op
    );
        logic [DEFAULT_WIDTH-1:0] y;
        y = '0;
        for (int i = 0; i < DEFAULT_WIDTH; i++) begin
            y[i] = apply_bit(a[i], b[i], op);
        end
        return y;
    endfunction

endpackage : logic_op_pkg
`default_nettype wire

// File: rtl/logic_op_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_responder_if
// Description : Request and response valid/ready channels of the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_op_responder_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [1:0]       rsp_op;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_op
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_op
    );
endinterface : logic_op_responder_if
`default_nettype wire

// File: rtl/logic_op_responder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth, unreset storage.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rstn,
    input  wire logic                       push,
    input  wire logic [DATA_W-1:0]          push_data,
    input  wire logic                       pop,
    output logic      [DATA_W-1:0]          head,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     count
);
    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full  = (c_ptr_w + 1)'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_full);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule : sync_fifo
`default_nettype wire

// File: rtl/logic_op_responder.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_responder
// Description : Computes bitwise logic results at request accept, buffers
//               them in a FIFO and returns them in order.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_responder
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    logic_op_responder_if.slave    bus,
    output logic [CNT_W-1:0]       txn_count
);
    localparam int c_data_w = WIDTH + 2;

    logic [WIDTH-1:0]       w_result;
    op_e                    w_op;
    logic                   w_push;
    logic                   w_pop;
    logic [c_data_w-1:0]    w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   r_ready_en;
    logic [c_data_w-1:0]    r_last;
    logic [CNT_W-1:0]       r_txn_count;

    assign w_op = op_e'(bus.req_op);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign w_result[gi] = apply_bit(bus.req_a[gi], bus.req_b[gi], w_op);
    end

    // r_ready_en keeps req_ready low until the first edge after reset release.
    assign bus.req_ready = r_ready_en && !w_full;
    assign bus.rsp_valid = (w_count != '0);
    assign w_push        = bus.req_valid && bus.req_ready;
    assign w_pop         = bus.rsp_valid && bus.rsp_ready;
    assign {bus.rsp_op, bus.rsp_y} = w_empty ? r_last : w_head;
    assign txn_count     = r_txn_count;

    sync_fifo #(
        .DATA_W (c_data_w),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push),
        .push_data ({bus.req_op, w_result}),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ready_en  <= 1'b0;
            r_last      <= '0;
            r_txn_count <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_pop) begin
                r_last      <= w_head;
                r_txn_count <= r_txn_count + CNT_W'(1);
            end
        end
    end
endmodule : logic_op_responder
`default_nettype wire
